// File: rtl/fft64_bf_sched.sv
// fft64_bf_sched: address and strobe sequencer for the one shared radix-2 butterfly
// of an in-place, memory-based DIF FFT (64 points by default).
//
// For each of LOG2N stages the block issues 2^(LOG2N-1) back-to-back dual-port reads
// with a twiddle index. Every read returns as a dual-port write PIPE_LAT cycles later.
// A PIPE_LAT-cycle drain between stages lets all writes of one stage land before the
// next stage starts reading.
//
// Ports
//   clk, rst               clock (rising edge); asynchronous active-high reset
//   start                  starts one transform; only looked at in IDLE
//   busy, done             busy runs from the cycle after start is accepted through done;
//                          done is a one-cycle pulse after the last write-back
//   stage                  index of the current stage
//   rd_en, rd_addr_0/1     read strobe and the upper/lower butterfly input addresses
//   tw_idx                 twiddle ROM index, valid in the same cycle as rd_en
//   wr_en, wr_addr_0/1     rd_en and read addresses delayed by PIPE_LAT cycles
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one butterfly read per cycle; b counts 0 .. 2^(LOG2N-1)-1
// DRAIN | no reads for PIPE_LAT cycles while the pipeline empties
// DONE  | one-cycle done pulse, then back to IDLE
module fft64_bf_sched #(
  parameter int LOG2N    = 6,
  parameter int PIPE_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [2:0]       stage,
  output logic             rd_en,
  output logic [LOG2N-1:0] rd_addr_0,
  output logic [LOG2N-1:0] rd_addr_1,
  output logic [LOG2N-2:0] tw_idx,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addr_0,
  output logic [LOG2N-1:0] wr_addr_1
);

  localparam int BW = LOG2N - 1;
  localparam int CW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [BW-1:0] B_LAST = '1;
  localparam logic [2:0]    S_LAST = 3'(LOG2N - 1);
  localparam logic [CW-1:0] D_LOAD = CW'(PIPE_LAT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        state_q, state_d;
  logic [2:0]    stage_q, stage_d;
  logic [BW-1:0] b_q, b_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      stage_q <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        if (b_q == B_LAST) begin
          state_d = DRAIN;
          cnt_d   = D_LOAD;
        end else begin
          b_d = b_q + 1'b1;
        end
      end
      DRAIN: begin
        if (cnt_q == '0) begin
          if (stage_q == S_LAST) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            stage_d = stage_q + 1'b1;
            b_d     = '0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        stage_d = '0;
        b_d     = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rd_en = (state_q == RUN);
  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);
  assign stage = stage_q;

  // Butterfly span is 2^p with p = LOG2N-1-stage. The upper address is b with a zero
  // inserted at bit p: bits of b below p stay in place, bits at p and above move up one.
  logic [2:0]       p;
  logic [LOG2N-1:0] unit, low_mask, b_ext, addr0;

  assign p        = S_LAST - stage_q;
  assign unit     = LOG2N'(1) << p;
  assign low_mask = unit - LOG2N'(1);
  assign b_ext    = {1'b0, b_q};
  assign addr0    = ((b_ext & ~low_mask) << 1) | (b_ext & low_mask);

  // Addresses are forced to zero outside RUN, so reset and idle outputs are all zero.
  assign rd_addr_0 = rd_en ? addr0 : '0;
  assign rd_addr_1 = rd_en ? (addr0 | unit) : '0;
  assign tw_idx    = rd_en ? ((b_q & low_mask[BW-1:0]) << stage_q) : '0;

  // Write-back delay line. It is the only source of the write port, so an async reset
  // drops wr_en immediately and discards any writes still in flight.
  logic             dl_en [PIPE_LAT];
  logic [LOG2N-1:0] dl_a0 [PIPE_LAT];
  logic [LOG2N-1:0] dl_a1 [PIPE_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        dl_en[i] <= 1'b0;
        dl_a0[i] <= '0;
        dl_a1[i] <= '0;
      end
    end else begin
      dl_en[0] <= rd_en;
      dl_a0[0] <= rd_addr_0;
      dl_a1[0] <= rd_addr_1;
      for (int i = 1; i < PIPE_LAT; i++) begin
        dl_en[i] <= dl_en[i-1];
        dl_a0[i] <= dl_a0[i-1];
        dl_a1[i] <= dl_a1[i-1];
      end
    end
  end

  assign wr_en     = dl_en[PIPE_LAT-1];
  assign wr_addr_0 = dl_a0[PIPE_LAT-1];
  assign wr_addr_1 = dl_a1[PIPE_LAT-1];

endmodule
